text_buffer_writer: RTL and testbench

Writable 16x16 character buffer: the write-side counterpart of the fixed menu text ROMs. A producer such as a menu FSM or UART bridge pushes glyph codes and cursor commands through a valid/ready handshake. The buffer stores one 7-bit glyph code per cell. The character renderer reads it through the same `char_xy` → `char_code` port as the ROM text sources, with identical 1-cycle latency, so the block drops in wherever a ROM text source is used.

---
 rtl/text_buffer_writer.sv | 112 +++++++++++
 tb/tb_text_buffer_writer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/text_buffer_writer.sv
// Writable 16x16 glyph buffer with a valid/ready command port and a ROM-compatible
// 1-cycle char_xy -> char_code read port; CLEAR sweeps all 256 cells with FILL_CODE.
module text_buffer_writer #(
  parameter logic [6:0] FILL_CODE      = 7'h20,  // matches vga_pkg::SPACE
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  input  logic [1:0] wr_cmd,
  input  logic [6:0] wr_char,
  output logic       wr_ready,
  input  logic [7:0] char_xy,
  output logic [6:0] char_code,
  output logic [7:0] cursor_xy,
  output logic       busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [1:0] CMD_PUT     = 2'b00;
  localparam logic [1:0] CMD_NEWLINE = 2'b01;
  localparam logic [1:0] CMD_HOME    = 2'b10;
  localparam logic [1:0] CMD_CLEAR   = 2'b11;

  localparam state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

  state_t     state_reg;
  logic [7:0] cursor_reg;
  logic [7:0] clr_addr_reg;
  logic [6:0] char_code_reg;
  logic [6:0] mem [256];

  logic       accept;
  logic       mem_we;
  logic [7:0] mem_waddr;
  logic [6:0] mem_wdata;

  // Ready depends only on the registered state, never on wr_valid.
  assign accept = wr_valid && (state_reg == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= RESET_STATE;
      cursor_reg   <= 8'h00;
      clr_addr_reg <= 8'h00;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            case (wr_cmd)
              CMD_PUT:     cursor_reg <= cursor_reg + 8'd1;
              CMD_NEWLINE: cursor_reg <= {cursor_reg[7:4] + 4'd1, 4'h0};
              CMD_HOME:    cursor_reg <= 8'h00;
              CMD_CLEAR: begin
                cursor_reg   <= 8'h00;
                clr_addr_reg <= 8'h00;
                state_reg    <= CLEAR;
              end
              default:     cursor_reg <= cursor_reg;
            endcase
          end
        end
        CLEAR: begin
          clr_addr_reg <= clr_addr_reg + 8'd1;
          if (clr_addr_reg == 8'hFF) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= RESET_STATE;
      endcase
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = cursor_reg;
    mem_wdata = wr_char;
    if (state_reg == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr_reg;
      mem_wdata = FILL_CODE;
    end else if (accept && (wr_cmd == CMD_PUT)) begin
      mem_we = 1'b1;
    end
  end

  // Storage has no reset so it maps onto block RAM; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Separate read register gives read-first behaviour on address collisions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_code_reg <= 7'h00;
    end else begin
      char_code_reg <= mem[char_xy];
    end
  end

  assign wr_ready  = (state_reg == IDLE);
  assign busy      = (state_reg == CLEAR);
  assign cursor_xy = cursor_reg;
  assign char_code = char_code_reg;

endmodule

// File: tb/tb_text_buffer_writer.sv
// Directed bench for text_buffer_writer: a cell-array/cursor model is checked against
// the DUT on every falling edge, plus hand-computed literal expectations.
module tb_text_buffer_writer;

  localparam logic [6:0] FILL = 7'h20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic [1:0] wr_cmd = 2'b10;
  logic [6:0] wr_char = 7'h00;
  logic       wr_ready;
  logic [7:0] char_xy = 8'h00;
  logic [6:0] char_code;
  logic [7:0] cursor_xy;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  text_buffer_writer #(.FILL_CODE(FILL), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_cmd(wr_cmd),
    .wr_char(wr_char), .wr_ready(wr_ready), .char_xy(char_xy),
    .char_code(char_code), .cursor_xy(cursor_xy), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: a 256-cell array, a cursor, and how many sweep cells are already filled.
  logic [6:0] m_mem [256];
  bit         m_known [256];
  int         m_sweep;
  int         m_cur;
  logic [6:0] m_code;
  bit         m_code_known;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cur        = 0;
      m_code       = 7'h00;
      m_code_known = 1'b1;
      m_sweep      = 0;
    end else begin
      m_code       = m_mem[char_xy];
      m_code_known = m_known[char_xy];
      if (m_sweep >= 0) begin
        m_mem[m_sweep]   = FILL;
        m_known[m_sweep] = 1'b1;
        m_sweep          = (m_sweep == 255) ? -1 : m_sweep + 1;
      end else if (wr_valid) begin
        case (wr_cmd)
          2'b00: begin
            m_mem[m_cur]   = wr_char;
            m_known[m_cur] = 1'b1;
            m_cur          = (m_cur + 1) % 256;
          end
          2'b01: m_cur = ((m_cur / 16 + 1) % 16) * 16;
          2'b10: m_cur = 0;
          default: begin
            m_cur   = 0;
            m_sweep = 0;
          end
        endcase
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model busy", {7'h0, busy}, {7'h0, m_sweep >= 0});
    chk("model wr_ready", {7'h0, wr_ready}, {7'h0, m_sweep < 0});
    chk("model cursor_xy", cursor_xy, m_cur[7:0]);
    if (m_code_known) chk("model char_code", {1'b0, char_code}, {1'b0, m_code});
  end

  task automatic send(input logic [1:0] cmd, input logic [6:0] ch);
    @(negedge clk);
    $display("cmd %0d char %h cursor %h", cmd, ch, cursor_xy);
    wr_valid = 1'b1;
    wr_cmd   = cmd;
    wr_char  = ch;
  endtask

  task automatic idle();
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic rd(input logic [7:0] addr, input logic [6:0] exp);
    @(negedge clk);
    wr_valid = 1'b0;
    char_xy  = addr;
    @(negedge clk);
    $display("read %h -> %h", addr, char_code);
    chk("read", {1'b0, char_code}, {1'b0, exp});
  endtask

  task automatic sweep_len(input string name);
    int n = 0;
    while (n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (!busy) break;
    end
    $display("sweep done after %0d cycles", n);
    chk(name, n[7:0], 8'd0);
    chk({name, " hi"}, n[15:8], 8'd1);
  endtask

  initial begin
    // Reset with a command held on the producer side.
    wr_valid = 1'b1;
    wr_cmd   = 2'b10;
    repeat (2) @(negedge clk);
    chk("rst cursor", cursor_xy, 8'h00);
    chk("rst code", {1'b0, char_code}, 8'h00);
    chk("rst busy", {7'h0, busy}, 8'h01);
    chk("rst ready", {7'h0, wr_ready}, 8'h00);
    rst_n = 1'b1;
    sweep_len("reset sweep");
    chk("post sweep ready", {7'h0, wr_ready}, 8'h01);
    idle();
    rd(8'h00, FILL);
    rd(8'h7F, FILL);
    rd(8'hFF, FILL);

    // Back-to-back PUTs from HOME.
    send(2'b10, 7'h00);
    send(2'b00, 7'h21);
    send(2'b00, 7'h22);
    send(2'b00, 7'h23);
    idle();
    chk("cursor after 3 puts", cursor_xy, 8'h03);
    rd(8'h00, 7'h21);
    rd(8'h01, 7'h22);
    rd(8'h02, 7'h23);

    // Column F advances to next row.
    for (int i = 0; i < 12; i++) send(2'b00, 7'h30 + 7'(i));
    send(2'b00, 7'h05);
    idle();
    chk("cursor 0F->10", cursor_xy, 8'h10);
    rd(8'h0F, 7'h05);

    // 0xFF wraps to 0x00.
    for (int i = 0; i < 14; i++) send(2'b01, 7'h00);
    for (int i = 0; i < 15; i++) send(2'b00, 7'h50 + 7'(i));
    idle();
    chk("cursor at FF", cursor_xy, 8'hFF);
    send(2'b00, 7'h7E);
    idle();
    chk("cursor FF wrap", cursor_xy, 8'h00);
    rd(8'hFF, 7'h7E);

    // NEWLINE from last row wraps and leaves memory untouched.
    for (int i = 0; i < 15; i++) send(2'b01, 7'h00);
    for (int i = 0; i < 7; i++) send(2'b00, 7'h41 + 7'(i));
    idle();
    chk("cursor at F7", cursor_xy, 8'hF7);
    send(2'b01, 7'h11);
    idle();
    chk("newline F7", cursor_xy, 8'h00);
    rd(8'hF7, 7'h57);

    send(2'b10, 7'h00);
    for (int i = 0; i < 3; i++) send(2'b01, 7'h00);
    for (int i = 0; i < 5; i++) send(2'b00, 7'h61 + 7'(i));
    send(2'b01, 7'h00);
    idle();
    chk("newline 35", cursor_xy, 8'h40);

    // Read-during-write at 0x12 returns old data first.
    send(2'b10, 7'h00);
    send(2'b01, 7'h00);
    send(2'b00, 7'h0A);
    send(2'b00, 7'h0B);
    idle();
    char_xy = 8'h12;
    send(2'b00, 7'h44);
    idle();
    chk("rdw old", {1'b0, char_code}, {1'b0, FILL});
    @(negedge clk);
    chk("rdw new", {1'b0, char_code}, 8'h44);

    // Accepted CLEAR, then reset mid-sweep at address 0x80.
    char_xy = 8'h0F;
    send(2'b11, 7'h00);
    idle();
    chk("clear busy", {7'h0, busy}, 8'h01);
    chk("clear cursor", cursor_xy, 8'h00);
    begin
      int guard = 0;
      while (m_sweep != 128 && guard < 400) begin
        @(negedge clk);
        guard++;
      end
      chk("reached 0x80", {7'h0, guard < 400}, 8'h01);
    end
    chk("code before reset", {1'b0, char_code}, {1'b0, FILL});
    #2 rst_n = 1'b0;
    #1;
    chk("async rst cursor", cursor_xy, 8'h00);
    chk("async rst code", {1'b0, char_code}, 8'h00);
    chk("async rst busy", {7'h0, busy}, 8'h01);
    chk("async rst ready", {7'h0, wr_ready}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    sweep_len("restart sweep");
    rd(8'h80, FILL);
    rd(8'h12, FILL);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
